rf_wb_ctrl: RTL and testbench

//  Write-back controller driving the integer register file's single write port. Merges

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_wb_ctrl_ld_queue.sv | 76 +++++++
 rtl/rf_wb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rf_wb_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back controller.
// Register address/data types, load queue entry and the x0 constant.
package rf_pkg;

   localparam int RF_WIDTH = 32;
   localparam int RF_DEPTH = 32;
   localparam int RF_AW    = $clog2(RF_DEPTH);

   typedef logic [RF_AW-1:0]    rf_addr_t;
   typedef logic [RF_WIDTH-1:0] rf_data_t;

   typedef struct packed {
      rf_addr_t rd;
      logic     killed;
   } ld_entry_t;

   localparam rf_addr_t X0 = '0;

endpackage

// File: rtl/rf_wb_ctrl_ld_queue.sv
// In-order outstanding-load FIFO with kill-all.
// Entries are kept compacted (slot 0 is the head) so the valid mask is a thermometer.
module rf_ld_queue
   import rf_pkg::*;
#(
   parameter int LD_PEND = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push_i,
   input  rf_addr_t            push_rd_i,
   input  logic                pop_i,
   input  logic                kill_i,
   output ld_entry_t           head_o,
   output logic                empty_o,
   output logic                full_o,
   output ld_entry_t           ent_o [LD_PEND],
   output logic [LD_PEND-1:0]  vld_o
);

   localparam int CW = $clog2(LD_PEND + 1);

   ld_entry_t      ent_q [LD_PEND];
   ld_entry_t      ent_d [LD_PEND];
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;

   // Pop shifts toward the head, kill marks survivors, push appends at the tail
   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (pop_i && cnt_q != '0) begin
         for (int i = 0; i < LD_PEND - 1; i++)
            ent_d[i] = ent_q[i+1];
         ent_d[LD_PEND-1] = '0;
         cnt_d = cnt_q - CW'(1);
      end
      if (kill_i) begin
         for (int i = 0; i < LD_PEND; i++)
            ent_d[i].killed = 1'b1;
      end
      if (push_i && int'(cnt_d) < LD_PEND) begin
         for (int i = 0; i < LD_PEND; i++) begin
            if (i == int'(cnt_d)) begin
               ent_d[i].rd     = push_rd_i;
               ent_d[i].killed = 1'b0;
            end
         end
         cnt_d = cnt_d + CW'(1);
      end
   end

   // Queue storage and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         for (int i = 0; i < LD_PEND; i++)
            ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         ent_q <= ent_d;
      end
   end

   // Status and scoreboard view
   always_comb begin
      for (int i = 0; i < LD_PEND; i++)
         vld_o[i] = (i < int'(cnt_q));
   end

   assign ent_o   = ent_q;
   assign head_o  = ent_q[0];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(LD_PEND));

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: merges load responses, ALU skid and ALU requests onto one RF port.
// Optional macro RF_WB_BYPASS_EN makes the rf_* outputs combinational (latency 0).
module rf_wb_ctrl
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int DEPTHMSB = $clog2(DEPTH) - 1,
   parameter int LD_PEND  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alu_valid_i,
   output logic                alu_ready_o,
   input  logic [DEPTHMSB:0]   alu_rd_i,
   input  logic [WIDTH-1:0]    alu_wd_i,
   input  logic                ld_issue_i,
   output logic                ld_issue_ready_o,
   input  logic [DEPTHMSB:0]   ld_issue_rd_i,
   input  logic                ld_rsp_valid_i,
   input  logic [WIDTH-1:0]    ld_rsp_data_i,
   input  logic                flush_i,
   output logic                rf_we_o,
   output logic [DEPTHMSB:0]   rf_wa_o,
   output logic [WIDTH-1:0]    rf_wd_o,
   output logic                rf_wb_en_o,
   output logic [DEPTH-1:0]    sb_busy_o,
   output logic                ld_err_o
);

   logic                skid_v_q, skid_v_d;
   logic [DEPTHMSB:0]   skid_rd_q, skid_rd_d;
   logic [WIDTH-1:0]    skid_wd_q, skid_wd_d;
   logic [DEPTHMSB:0]   wa_q, wa_d;
   logic [WIDTH-1:0]    wd_q, wd_d;
   logic                err_q, err_d;

   ld_entry_t           q_head;
   ld_entry_t           q_ent [LD_PEND];
   logic [LD_PEND-1:0]  q_vld;
   logic                q_empty, q_full;

   logic                rsp_pop, alu_acc, q_push;
   logic                sel_ld, sel_skid, sel_alu;
   logic                wr_v, wr_kill;
   logic [DEPTHMSB:0]   wr_rd;
   logic [WIDTH-1:0]    wr_wd;
   logic                we_c;
   logic [DEPTHMSB:0]   wa_c;
   logic [WIDTH-1:0]    wd_c;

   assign rsp_pop = ld_rsp_valid_i & ~q_empty;
   assign alu_acc = alu_valid_i & ~skid_v_q & ~flush_i;
   assign q_push  = ld_issue_i & ~flush_i & (~q_full | rsp_pop);

   assign alu_ready_o      = ~skid_v_q;
   assign ld_issue_ready_o = ~q_full;

   rf_ld_queue #(.LD_PEND(LD_PEND)) u_ldq (
      .clk       (clk),
      .rst       (rst),
      .push_i    (q_push),
      .push_rd_i (ld_issue_rd_i),
      .pop_i     (rsp_pop),
      .kill_i    (flush_i),
      .head_o    (q_head),
      .empty_o   (q_empty),
      .full_o    (q_full),
      .ent_o     (q_ent),
      .vld_o     (q_vld)
   );

   // Priority select: load response, then skid, then fresh ALU request
   always_comb begin
      sel_ld   = rsp_pop;
      sel_skid = ~sel_ld & skid_v_q & ~flush_i;
      sel_alu  = ~sel_ld & ~skid_v_q & alu_acc;
      wr_v     = 1'b0;
      wr_kill  = 1'b0;
      wr_rd    = '0;
      wr_wd    = '0;
      unique case (1'b1)
         sel_ld: begin
            wr_v    = 1'b1;
            wr_rd   = q_head.rd;
            wr_wd   = ld_rsp_data_i;
            wr_kill = q_head.killed | flush_i;
         end
         sel_skid: begin
            wr_v  = 1'b1;
            wr_rd = skid_rd_q;
            wr_wd = skid_wd_q;
         end
         sel_alu: begin
            wr_v  = 1'b1;
            wr_rd = alu_rd_i;
            wr_wd = alu_wd_i;
         end
         default: ;
      endcase
      we_c = wr_v & ~wr_kill & (wr_rd != X0);
      wa_c = wa_q;
      wd_c = wd_q;
      if (wr_v) begin
         wa_c = we_c ? wr_rd : '0;
         wd_c = we_c ? wr_wd : '0;
      end
   end

   // Skid captures an accepted ALU request that lost arbitration
   always_comb begin
      skid_v_d  = skid_v_q;
      skid_rd_d = skid_rd_q;
      skid_wd_d = skid_wd_q;
      if (flush_i) begin
         skid_v_d = 1'b0;
      end else if (alu_acc && !sel_alu) begin
         skid_v_d  = 1'b1;
         skid_rd_d = alu_rd_i;
         skid_wd_d = alu_wd_i;
      end else if (sel_skid) begin
         skid_v_d = 1'b0;
      end
      wa_d  = wa_c;
      wd_d  = wd_c;
      err_d = ld_rsp_valid_i & q_empty;
   end

   // Skid, held write address/data and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_v_q  <= 1'b0;
         skid_rd_q <= '0;
         skid_wd_q <= '0;
         wa_q      <= '0;
         wd_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         skid_v_q  <= skid_v_d;
         skid_rd_q <= skid_rd_d;
         skid_wd_q <= skid_wd_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
      end
   end

   assign ld_err_o = err_q;

`ifdef RF_WB_BYPASS_EN
   assign rf_we_o    = we_c;
   assign rf_wb_en_o = we_c;
   assign rf_wa_o    = wa_c;
   assign rf_wd_o    = wd_c;
`else
   logic we_q, we_d;

   assign we_d = we_c;

   // Registered write enable
   always_ff @(posedge clk) begin
      if (rst) we_q <= 1'b0;
      else     we_q <= we_d;
   end

   assign rf_we_o    = we_q;
   assign rf_wb_en_o = we_q;
   assign rf_wa_o    = wa_q;
   assign rf_wd_o    = wd_q;
`endif

   // Scoreboard: destinations of live (not killed) queued loads
   always_comb begin
      sb_busy_o = '0;
      for (int i = 0; i < LD_PEND; i++) begin
         if (q_vld[i] && !q_ent[i].killed)
            sb_busy_o[q_ent[i].rd] = 1'b1;
      end
      sb_busy_o[0] = 1'b0;
   end

`ifndef SYNTHESIS
   a_alu_rd_not_busy: assert property (@(posedge clk) disable iff (rst)
      (alu_valid_i && alu_ready_o && !flush_i) |-> !sb_busy_o[alu_rd_i]);
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl (default registered-output build).
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_rf_wb_ctrl;

   localparam int LD_PEND = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wd;
   logic        ld_issue;
   logic        ld_issue_ready;
   logic [4:0]  ld_issue_rd;
   logic        ld_rsp_valid;
   logic [31:0] ld_rsp_data;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        rf_wb_en;
   logic [31:0] sb_busy;
   logic        ld_err;

   int n_assert = 0;
   int n_fail   = 0;
   bit started  = 0;

   always #5 clk = ~clk;

   rf_wb_ctrl #(.LD_PEND(LD_PEND)) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_valid_i      (alu_valid),
      .alu_ready_o      (alu_ready),
      .alu_rd_i         (alu_rd),
      .alu_wd_i         (alu_wd),
      .ld_issue_i       (ld_issue),
      .ld_issue_ready_o (ld_issue_ready),
      .ld_issue_rd_i    (ld_issue_rd),
      .ld_rsp_valid_i   (ld_rsp_valid),
      .ld_rsp_data_i    (ld_rsp_data),
      .flush_i          (flush),
      .rf_we_o          (rf_we),
      .rf_wa_o          (rf_wa),
      .rf_wd_o          (rf_wd),
      .rf_wb_en_o       (rf_wb_en),
      .sb_busy_o        (sb_busy),
      .ld_err_o         (ld_err)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int rd;
      bit killed;
   } mld_t;

   mld_t        mq[$];
   bit          m_skid_v = 0;
   int          m_skid_rd = 0;
   logic [31:0] m_skid_wd = 0;
   bit          e_we = 0;
   int          e_wa = 0;
   logic [31:0] e_wd = 0;
   bit          e_err = 0;

   function automatic void put(int rd, logic [31:0] d, bit kill);
      if (kill || rd == 0) begin
         e_we = 0; e_wa = 0; e_wd = 0;
      end else begin
         e_we = 1; e_wa = rd; e_wd = d;
      end
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b = 0;
      foreach (mq[i])
         if (!mq[i].killed && mq[i].rd != 0) b[mq[i].rd] = 1'b1;
      return b;
   endfunction

   always @(posedge clk) begin
      automatic bit alu_ok;
      automatic bit have_rsp;
      automatic mld_t e;
      if (rst) begin
         mq.delete();
         m_skid_v = 0;
         e_we = 0; e_wa = 0; e_wd = 0; e_err = 0;
      end else begin
         e_err    = ld_rsp_valid && mq.size() == 0;
         have_rsp = ld_rsp_valid && mq.size() > 0;
         alu_ok   = alu_valid && !m_skid_v && !flush;
         if (have_rsp) begin
            e = mq.pop_front();
            put(e.rd, ld_rsp_data, e.killed || flush);
         end else if (m_skid_v && !flush) begin
            put(m_skid_rd, m_skid_wd, 0);
            m_skid_v = 0;
         end else if (alu_ok) begin
            put(int'(alu_rd), alu_wd, 0);
            alu_ok = 0;
         end else begin
            e_we = 0;
         end
         if (flush) m_skid_v = 0;
         else if (alu_ok) begin
            m_skid_v = 1; m_skid_rd = int'(alu_rd); m_skid_wd = alu_wd;
         end
         if (flush) foreach (mq[i]) mq[i].killed = 1;
         if (ld_issue && !flush && mq.size() < LD_PEND)
            mq.push_back('{rd: int'(ld_issue_rd), killed: 0});
      end
      started = 1;
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("m_we",    64'(rf_we),          64'(e_we));
         chk("m_wben",  64'(rf_wb_en),       64'(e_we));
         chk("m_wa",    64'(rf_wa),          64'(e_wa));
         chk("m_wd",    64'(rf_wd),          64'(e_wd));
         chk("m_err",   64'(ld_err),         64'(e_err));
         chk("m_ardy",  64'(alu_ready),      64'(!m_skid_v));
         chk("m_irdy",  64'(ld_issue_ready), 64'(mq.size() < LD_PEND));
         chk("m_busy",  64'(sb_busy),        64'(m_busy()));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_wd = 0;
      ld_issue = 0; ld_issue_rd = 0;
      ld_rsp_valid = 0; ld_rsp_data = 0;
      flush = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic alu(input int rd, input logic [31:0] d);
      alu_valid = 1; alu_rd = 5'(rd); alu_wd = d;
   endtask

   task automatic iss(input int rd);
      ld_issue = 1; ld_issue_rd = 5'(rd);
   endtask

   task automatic rsp(input logic [31:0] d);
      ld_rsp_valid = 1; ld_rsp_data = d;
   endtask

   initial begin
      rst = 1;
      idle();
      cyc();
      cyc();
      chk("rst_we",   64'(rf_we),          64'd0);
      chk("rst_wa",   64'(rf_wa),          64'd0);
      chk("rst_ardy", 64'(alu_ready),      64'd1);
      chk("rst_irdy", 64'(ld_issue_ready), 64'd1);
      chk("rst_busy", 64'(sb_busy),        64'd0);
      rst = 0;
      cyc();

      alu(5, 32'hDEADBEEF);
      cyc();
      chk("alu_we",   64'(rf_we),    64'd1);
      chk("alu_wben", 64'(rf_wb_en), 64'd1);
      chk("alu_wa",   64'(rf_wa),    64'd5);
      chk("alu_wd",   64'(rf_wd),    64'hDEADBEEF);
      cyc();
      chk("idle_we",  64'(rf_we),    64'd0);
      chk("idle_wa",  64'(rf_wa),    64'd5);

      iss(7);
      cyc();
      chk("ld7_busy", 64'(sb_busy[7]), 64'd1);
      rsp(32'h1234);
      alu(3, 32'h55);
      cyc();
      chk("ld7_wa",   64'(rf_wa),      64'd7);
      chk("ld7_wd",   64'(rf_wd),      64'h1234);
      chk("ld7_ardy", 64'(alu_ready),  64'd0);
      chk("ld7_busy0",64'(sb_busy[7]), 64'd0);
      cyc();
      chk("skid_we",  64'(rf_we),      64'd1);
      chk("skid_wa",  64'(rf_wa),      64'd3);
      chk("skid_wd",  64'(rf_wd),      64'h55);
      chk("skid_ardy",64'(alu_ready),  64'd1);

      iss(1);
      cyc();
      iss(2);
      cyc();
      chk("full_irdy", 64'(ld_issue_ready), 64'd0);
      rsp(32'hA1);
      iss(4);
      cyc();
      chk("full_wa",   64'(rf_wa),   64'd1);
      chk("full_wd",   64'(rf_wd),   64'hA1);
      chk("full_busy", 64'(sb_busy), 64'h14);
      chk("full_irdy2",64'(ld_issue_ready), 64'd0);
      rsp(32'hA2);
      cyc();
      chk("dr_wa2",    64'(rf_wa),   64'd2);
      rsp(32'hA4);
      cyc();
      chk("dr_wa4",    64'(rf_wa),   64'd4);
      chk("dr_busy",   64'(sb_busy), 64'd0);

      iss(8);
      cyc();
      iss(9);
      cyc();
      chk("fl_busy_pre", 64'(sb_busy), 64'h300);
      flush = 1;
      cyc();
      chk("fl_busy", 64'(sb_busy), 64'd0);
      rsp(32'hBB);
      cyc();
      chk("fl_we1", 64'(rf_we), 64'd0);
      chk("fl_wd1", 64'(rf_wd), 64'd0);
      rsp(32'hCC);
      cyc();
      chk("fl_we2", 64'(rf_we), 64'd0);
      chk("fl_irdy",64'(ld_issue_ready), 64'd1);

      alu(0, 32'h77);
      cyc();
      chk("x0_alu_we", 64'(rf_we), 64'd0);
      iss(0);
      cyc();
      rsp(32'h99);
      cyc();
      chk("x0_ld_we", 64'(rf_we), 64'd0);
      rsp(32'hEE);
      cyc();
      chk("stray_err", 64'(ld_err), 64'd1);
      chk("stray_we",  64'(rf_we),  64'd0);
      cyc();
      chk("stray_err0",64'(ld_err), 64'd0);

      iss(10);
      cyc();
      iss(11);
      cyc();
      chk("pr_busy", 64'(sb_busy), 64'hC00);
      rst = 1;
      cyc();
      chk("mr_busy", 64'(sb_busy),        64'd0);
      chk("mr_ardy", 64'(alu_ready),      64'd1);
      chk("mr_irdy", 64'(ld_issue_ready), 64'd1);
      rst = 0;
      rsp(32'h1);
      cyc();
      chk("mr_err",  64'(ld_err), 64'd1);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
